sopc_onchip_mem_arbiter: RTL and testbench

//  Two-master Avalon-MM arbiter for the 32-bit single-port on-chip RAM (1-cycle read latency).

---
 rtl/sopc_onchip_mem_arbiter.sv | 91 +++++++++
 tb/tb_sopc_onchip_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_onchip_mem_arbiter.sv
// sopc_onchip_mem_arbiter: two-master burst-limited round-robin arbiter for a 1-cycle-latency on-chip RAM
// Define SOPC_ARB_FIXED_PRIO_EN to make m0 win every tie instead.
module sopc_onchip_mem_arbiter #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 32,
   parameter int NUMWORDS  = 10000,
   parameter int MAX_BURST = 4,
   localparam int BE_W     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUMWORDS);
   logic r0, r1, gv, g, wr, in_rng;
   logic rd_pend, rd_tag, rd_oor;
   assign r0 = m0_read | m0_write;
   assign r1 = m1_read | m1_write;
`ifdef SOPC_ARB_FIXED_PRIO_EN
   assign g = ~r0;
`else
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MB = CW'(MAX_BURST);
   logic owner;
   logic [CW-1:0] cnt;
   // the owner keeps the port on a tie until its burst allowance runs out
   assign g = (r0 & r1) ? ((cnt < MB) ? owner : ~owner) : ~r0;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner <= 1'b0;
         cnt   <= '0;
      end else if (!gv) begin
         cnt <= '0;
      end else if (g == owner) begin
         cnt <= (cnt == MB) ? MB : cnt + CW'(1);
      end else begin
         owner <= g;
         cnt   <= CW'(1);
      end
   end
`endif
   assign gv             = reset_n & (r0 | r1);
   assign mem_address    = g ? m1_address : m0_address;
   assign mem_byteenable = g ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = g ? m1_writedata : m0_writedata;
   assign wr             = g ? m1_write : m0_write;
   assign in_rng         = {1'b0, mem_address} < LIMIT;
   assign mem_chipselect = gv & in_rng;
   assign mem_write      = mem_chipselect & wr;
   assign mem_clken      = 1'b1;
   assign m0_waitrequest = ~(gv & ~g);
   assign m1_waitrequest = ~(gv & g);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend <= 1'b0;
         rd_tag  <= 1'b0;
         rd_oor  <= 1'b0;
      end else begin
         rd_pend <= gv & ~wr;
         rd_tag  <= g;
         rd_oor  <= ~in_rng;
      end
   end
   // out-of-range reads complete with zero data rather than whatever the RAM drives
   assign m0_readdatavalid = rd_pend & ~rd_tag;
   assign m1_readdatavalid = rd_pend & rd_tag;
   assign m0_readdata      = (m0_readdatavalid & ~rd_oor) ? mem_readdata : '0;
   assign m1_readdata      = (m1_readdatavalid & ~rd_oor) ? mem_readdata : '0;
endmodule

// File: tb/tb_sopc_onchip_mem_arbiter.sv
// tb_sopc_onchip_mem_arbiter: directed and randomized checks of the arbiter against a
// transaction-level model with a reference memory image.
module tb_sopc_onchip_mem_arbiter;
   localparam int AW = 14, DW = 32, NW = 10000, MB = 4;
   logic clk = 1'b0, reset_n = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] m0_address, m1_address, mem_address;
   logic m0_read, m0_write, m1_read, m1_write;
   logic [3:0] m0_byteenable, m1_byteenable, mem_byteenable;
   logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata;
   logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic mem_chipselect, mem_write, mem_clken;
   logic [DW-1:0] mem_readdata = '0;

   sopc_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUMWORDS(NW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata));

   // single-port RAM with registered output
   logic [DW-1:0] ram [NW] = '{default: '0};
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken && int'(mem_address) < NW) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[int'(mem_address)][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= ram[int'(mem_address)];
         end
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   // transaction each master is presenting
   logic t_rd [2], t_wr [2];
   logic [AW-1:0] t_a [2];
   logic [3:0] t_be [2];
   logic [31:0] t_d [2];

   // model: memory image, who holds the port and for how many consecutive grants, expected returns
   logic [31:0] ref_mem [NW];
   int owner_m = 0, run_m = 0;
   bit exp_rv [2];
   logic [31:0] exp_rd [2];

   task automatic set_txn(input int x, input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
      t_rd[x] = r; t_wr[x] = w; t_a[x] = a; t_be[x] = be; t_d[x] = d;
   endtask

   task automatic idle(input int x);
      set_txn(x, 0, 0, '0, '0, '0);
   endtask

   task automatic drive();
      m0_read = t_rd[0]; m0_write = t_wr[0]; m0_address = t_a[0];
      m0_byteenable = t_be[0]; m0_writedata = t_d[0];
      m1_read = t_rd[1]; m1_write = t_wr[1]; m1_address = t_a[1];
      m1_byteenable = t_be[1]; m1_writedata = t_d[1];
   endtask

   // one clock cycle: drive, compare every output against the model, then advance the model
   task automatic cyc(output int g, output int gd);
      bit q0, q1, oor;
      int gi;
      logic [AW-1:0] a;
      @(negedge clk);
      drive();
      #2;
      q0 = t_rd[0] | t_wr[0];
      q1 = t_rd[1] | t_wr[1];
      if (q0 && q1) begin
`ifdef SOPC_ARB_FIXED_PRIO_EN
         g = 0;
`else
         g = (run_m < MB) ? owner_m : 1 - owner_m;
`endif
      end else begin
         g = q0 ? 0 : (q1 ? 1 : -1);
      end
      gd = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(g != 0));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(g != 1));
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(exp_rv[0]));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(exp_rv[1]));
      if (exp_rv[0]) chk("m0_readdata", m0_readdata, exp_rd[0]);
      if (exp_rv[1]) chk("m1_readdata", m1_readdata, exp_rd[1]);
      gi = (g < 0) ? 0 : g;
      a = t_a[gi];
      oor = int'(a) >= NW;
      chk("mem_chipselect", 32'(mem_chipselect), 32'(g >= 0 && !oor));
      chk("mem_write", 32'(mem_write), 32'(g >= 0 && !oor && t_wr[gi]));
      chk("mem_clken", 32'(mem_clken), 32'(1));
      if (g >= 0 && !oor) chk("mem_address", 32'(mem_address), 32'(a));
      if (g >= 0 && !oor && t_wr[gi]) begin
         chk("mem_byteenable", 32'(mem_byteenable), 32'(t_be[gi]));
         chk("mem_writedata", mem_writedata, t_d[gi]);
      end
      exp_rv[0] = 0;
      exp_rv[1] = 0;
      if (g >= 0) begin
         if (t_wr[gi]) begin
            if (!oor)
               for (int b = 0; b < 4; b++)
                  if (t_be[gi][b]) ref_mem[int'(a)][8*b +: 8] = t_d[gi][8*b +: 8];
         end else begin
            exp_rv[gi] = 1;
            exp_rd[gi] = oor ? 32'h0 : ref_mem[int'(a)];
         end
      end
      if (g < 0) run_m = 0;
      else if (g == owner_m) run_m = (run_m < MB) ? run_m + 1 : MB;
      else begin
         owner_m = g;
         run_m = 1;
      end
   endtask

   // assert reset just after an edge, check quiescent outputs while low, release one cycle later
   task automatic do_reset();
      @(posedge clk);
      #1 reset_n = 1'b0;
      #2;
      chk("rst_m0_waitrequest", 32'(m0_waitrequest), 32'(1));
      chk("rst_m1_waitrequest", 32'(m1_waitrequest), 32'(1));
      chk("rst_m0_readdatavalid", 32'(m0_readdatavalid), 32'(0));
      chk("rst_m1_readdatavalid", 32'(m1_readdatavalid), 32'(0));
      chk("rst_mem_chipselect", 32'(mem_chipselect), 32'(0));
      chk("rst_mem_write", 32'(mem_write), 32'(0));
      chk("rst_m0_readdata", m0_readdata, 32'h0);
      chk("rst_m1_readdata", m1_readdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      idle(0);
      idle(1);
      drive();
      reset_n = 1'b1;
      owner_m = 0;
      run_m = 0;
      exp_rv[0] = 0;
      exp_rv[1] = 0;
   endtask

   int exp_seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
   bit act [2];
   int wait_n [2];

   initial begin
      int g, gd, sel;
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
      idle(0);
      idle(1);
      drive();
      do_reset();

      // write then read back through m0
      set_txn(0, 0, 1, 14'h0010, 4'hF, 32'hDEADBEEF);
      cyc(g, gd);
      chk("t1_write_grant", 32'(gd), 32'(0));
      set_txn(0, 1, 0, 14'h0010, 4'hF, 32'h0);
      cyc(g, gd);
      chk("t1_read_grant", 32'(gd), 32'(0));
      idle(0);
      cyc(g, gd);
      chk("t1_rdv", 32'(m0_readdatavalid), 32'(1));
      chk("t1_data", m0_readdata, 32'hDEADBEEF);
      chk("t1_m1_rdv", 32'(m1_readdatavalid), 32'(0));

      // both masters reading continuously: bursts of MAX_BURST alternate
      cyc(g, gd);
      set_txn(0, 1, 0, 14'h0010, 4'hF, 32'h0);
      set_txn(1, 1, 0, 14'h0011, 4'hF, 32'h0);
      for (int i = 0; i < 12; i++) begin
         cyc(g, gd);
         chk("t2_grant", 32'(gd), 32'(exp_seq[i]));
      end
      idle(0);
      idle(1);
      cyc(g, gd);

      // byte-lane merge across masters
      set_txn(0, 0, 1, 14'h0020, 4'hF, 32'hAAAAAAAA);
      cyc(g, gd);
      idle(0);
      set_txn(1, 0, 1, 14'h0020, 4'b0101, 32'h11223344);
      cyc(g, gd);
      set_txn(1, 1, 0, 14'h0020, 4'hF, 32'h0);
      cyc(g, gd);
      idle(1);
      cyc(g, gd);
      chk("t3_rdv", 32'(m1_readdatavalid), 32'(1));
      chk("t3_data", m1_readdata, 32'hAA22AA44);

      // out-of-range write and read at NUMWORDS
      set_txn(1, 0, 1, 14'h2710, 4'hF, 32'h12345678);
      cyc(g, gd);
      chk("t4_wr_grant", 32'(gd), 32'(1));
      chk("t4_wr_cs", 32'(mem_chipselect), 32'(0));
      set_txn(1, 1, 0, 14'h2710, 4'hF, 32'h0);
      cyc(g, gd);
      chk("t4_rd_cs", 32'(mem_chipselect), 32'(0));
      idle(1);
      cyc(g, gd);
      chk("t4_rdv", 32'(m1_readdatavalid), 32'(1));
      chk("t4_data", m1_readdata, 32'h0);

      // reset discards a pending read; afterwards m0 owns the port again
      set_txn(0, 1, 0, 14'h0010, 4'hF, 32'h0);
      cyc(g, gd);
      chk("t5_m0_grant", 32'(gd), 32'(0));
      do_reset();
      set_txn(1, 1, 0, 14'h0011, 4'hF, 32'h0);
      cyc(g, gd);
      chk("t5_m1_grant", 32'(gd), 32'(1));
      do_reset();
      cyc(g, gd);
      chk("t5_no_rdv", 32'(m0_readdatavalid | m1_readdatavalid), 32'(0));
      set_txn(0, 1, 0, 14'h0010, 4'hF, 32'h0);
      set_txn(1, 1, 0, 14'h0011, 4'hF, 32'h0);
      cyc(g, gd);
      chk("t5_first_grant", 32'(gd), 32'(0));
      idle(0);
      idle(1);
      cyc(g, gd);

`ifdef SOPC_ARB_FIXED_PRIO_EN
      set_txn(0, 1, 0, 14'h0001, 4'hF, 32'h0);
      set_txn(1, 1, 0, 14'h0002, 4'hF, 32'h0);
      for (int i = 0; i < 10; i++) begin
         cyc(g, gd);
         chk("t6_grant", 32'(gd), 32'(0));
         chk("t6_m1_wait", 32'(m1_waitrequest), 32'(1));
      end
      idle(0);
      idle(1);
      cyc(g, gd);
`endif

      // randomized traffic, requests held until accepted
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            act[0] = 0;
            act[1] = 0;
         end
         for (int x = 0; x < 2; x++) begin
            if (!act[x] && $urandom_range(0, 9) < 7) begin
               sel = $urandom_range(0, 15);
               t_a[x] = (sel < 13) ? 14'($urandom_range(0, 31)) :
                        (sel == 13) ? 14'd9999 : (sel == 14) ? 14'd10000 :
                        14'($urandom_range(10000, 16383));
               sel = $urandom_range(0, 5);
               t_rd[x] = (sel < 3) || (sel == 5);
               t_wr[x] = (sel >= 3);
               t_be[x] = 4'($urandom_range(0, 15));
               t_d[x] = $urandom;
               act[x] = 1;
               wait_n[x] = 0;
            end else if (!act[x]) begin
               idle(x);
            end
         end
         cyc(g, gd);
         for (int x = 0; x < 2; x++) begin
            if (act[x]) begin
               if (g == x) act[x] = 0;
               else begin
                  wait_n[x]++;
`ifndef SOPC_ARB_FIXED_PRIO_EN
                  chk("fair_wait", 32'(wait_n[x] <= MB), 32'(1));
`endif
               end
            end
         end
      end
      idle(0);
      idle(1);
      cyc(g, gd);
      cyc(g, gd);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
